// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, tick-gated majority-vote FSM,
// and a single-word output register with read handshake and sticky overrun.
module uart_rx_os #(
  parameter int unsigned c_OVERSAMPLE = 3,
  parameter int unsigned c_DATABITS   = 8,
  parameter int unsigned c_PARITY     = 0,
  parameter int unsigned c_STOPBITS   = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_tick,
  input  logic                  i_rx,
  input  logic                  i_read,
  output logic [c_DATABITS-1:0] o_data,
  output logic                  o_avail,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break,
  output logic                  o_overrun
);

  localparam int unsigned TW  = $clog2(c_OVERSAMPLE);
  localparam int unsigned BW  = $clog2(c_DATABITS + 1);
  localparam int unsigned MID = c_OVERSAMPLE / 2;

  localparam logic [TW-1:0] T_S0   = TW'(MID - 1);
  localparam logic [TW-1:0] T_S1   = TW'(MID);
  localparam logic [TW-1:0] T_VOTE = TW'(MID + 1);
  localparam logic [TW-1:0] T_LAST = TW'(c_OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(c_DATABITS - 1);
  localparam logic          HAS_PAR = (c_PARITY != 0);
  localparam logic          S_LAST  = (c_STOPBITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                r_STATE;
  logic [1:0]            r_SYNC;
  logic                  r_PREV;
  logic [TW-1:0]         r_TCNT;
  logic [BW-1:0]         r_BCNT;
  logic                  r_SCNT;
  logic                  r_S0;
  logic                  r_S1;
  logic [c_DATABITS-1:0] r_SHIFT;
  logic                  r_PBIT;
  logic                  r_FERR;

  logic w_rx;
  logic w_vote;
  logic w_ferr;
  logic w_perr;
  logic w_break;
  logic w_done;

  assign w_rx    = r_SYNC[1];
  // Third sample is the live level at index mid+1, so the vote is ready on that tick.
  assign w_vote  = (r_S0 & r_S1) | (r_S0 & w_rx) | (r_S1 & w_rx);
  assign w_ferr  = r_FERR | ~w_vote;
  assign w_perr  = HAS_PAR && ((^r_SHIFT ^ r_PBIT) != (c_PARITY == 1));
  assign w_break = w_ferr && (r_SHIFT == '0) && (!HAS_PAR || !r_PBIT);
  assign w_done  = i_tick && (r_STATE == S_STOP) && (r_TCNT == T_VOTE) && (r_SCNT == S_LAST);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_SYNC <= 2'b11;
    else            r_SYNC <= {r_SYNC[0], i_rx};
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_STATE      <= S_IDLE;
      r_PREV       <= 1'b0;
      r_TCNT       <= '0;
      r_BCNT       <= '0;
      r_SCNT       <= 1'b0;
      r_S0         <= 1'b0;
      r_S1         <= 1'b0;
      r_SHIFT      <= '0;
      r_PBIT       <= 1'b0;
      r_FERR       <= 1'b0;
      o_data       <= '0;
      o_avail      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (i_tick) begin
        if (r_STATE != S_IDLE) begin
          r_TCNT <= (r_TCNT == T_LAST) ? '0 : r_TCNT + 1'b1;
          if (r_TCNT == T_S0) r_S0 <= w_rx;
          if (r_TCNT == T_S1) r_S1 <= w_rx;
        end
        // Bit actions fire at index mid+1, state advances at the bit's last index;
        // both can land on the same tick for small oversample factors.
        case (r_STATE)
          S_IDLE: begin
            r_PREV <= w_rx;
            if (r_PREV && !w_rx) begin
              r_STATE <= S_START;
              r_TCNT  <= TW'(1);
              r_S0    <= 1'b0;
              r_BCNT  <= '0;
              r_SCNT  <= 1'b0;
              r_FERR  <= 1'b0;
            end
          end
          S_START: begin
            if (r_TCNT == T_VOTE && w_vote) begin
              r_STATE <= S_IDLE;
              r_PREV  <= 1'b1;
              r_TCNT  <= '0;
            end else if (r_TCNT == T_LAST) begin
              r_STATE <= S_DATA;
            end
          end
          S_DATA: begin
            if (r_TCNT == T_VOTE) r_SHIFT <= {w_vote, r_SHIFT[c_DATABITS-1:1]};
            if (r_TCNT == T_LAST) begin
              if (r_BCNT == B_LAST) r_STATE <= HAS_PAR ? S_PARITY : S_STOP;
              else                  r_BCNT  <= r_BCNT + 1'b1;
            end
          end
          S_PARITY: begin
            if (r_TCNT == T_VOTE) r_PBIT  <= w_vote;
            if (r_TCNT == T_LAST) r_STATE <= S_STOP;
          end
          S_STOP: begin
            if (r_TCNT == T_VOTE) begin
              r_FERR <= w_ferr;
              if (r_SCNT == S_LAST) begin
                r_STATE <= S_IDLE;
                r_PREV  <= w_vote;
                r_TCNT  <= '0;
              end
            end
            if (r_TCNT == T_LAST && r_SCNT != S_LAST) r_SCNT <= 1'b1;
          end
          default: r_STATE <= S_IDLE;
        endcase
      end

      if (w_done) begin
        o_data       <= r_SHIFT;
        o_parity_err <= w_perr;
        o_frame_err  <= w_ferr;
        o_break      <= w_break;
        o_avail      <= 1'b1;
        if (o_avail) o_overrun <= !i_read;
      end else if (i_read && o_avail) begin
        o_avail   <= 1'b0;
        o_overrun <= 1'b0;
      end
    end
  end

endmodule
